// File: rtl/alu_issue_unit.sv
// Issue side of a combinational ALU: accepts one request, drives the ALU from latched
// operands, then either writes back the result or updates sticky compare flags.
module alu_issue_unit #(
   parameter int DATA_W = 8,
   parameter int DEST_W = 3,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [2:0]        req_aluop,
   input  logic [DATA_W-1:0] req_op1,
   input  logic [DATA_W-1:0] req_op2,
   input  logic [DEST_W-1:0] req_dest,
   output logic [DATA_W-1:0] alu_op1,
   output logic [DATA_W-1:0] alu_op2,
   output logic [2:0]        alu_aluop,
   input  logic [DATA_W-1:0] alu_result,
   input  logic              alu_equal,
   input  logic              alu_less,
   output logic              wb_valid,
   input  logic              wb_ready,
   output logic [DEST_W-1:0] wb_dest,
   output logic [DATA_W-1:0] wb_data,
   output logic              flag_equal,
   output logic              flag_less,
   output logic [CNT_W-1:0]  retired_count
);

   typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

   typedef struct packed {
      logic [2:0]        aluop;
      logic [DATA_W-1:0] op1;
      logic [DATA_W-1:0] op2;
      logic [DEST_W-1:0] dest;
   } req_t;

   localparam logic [2:0] OP_SLT  = 3'b101;
   localparam logic [2:0] OP_SLTE = 3'b110;
   localparam logic [2:0] OP_EQ   = 3'b111;

   state_t state, state_nx;
   req_t   req_q;
   logic   accept, is_cmp, retire;

   assign alu_op1   = req_q.op1;
   assign alu_op2   = req_q.op2;
   assign alu_aluop = req_q.aluop;
   assign is_cmp    = (req_q.aluop >= OP_SLT);

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      req_ready = 1'b0;
      wb_valid  = 1'b0;
      accept    = 1'b0;
      retire    = 1'b0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               accept   = 1'b1;
               state_nx = EXEC;
            end
         end
         EXEC: begin
            // compares finish here; everything else needs a writeback slot
            if (is_cmp) begin
               retire   = 1'b1;
               state_nx = IDLE;
            end else begin
               state_nx = WB;
            end
         end
         WB: begin
            wb_valid = 1'b1;
            if (wb_ready) begin
               retire   = 1'b1;
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         req_q         <= '0;
         wb_dest       <= '0;
         wb_data       <= '0;
         flag_equal    <= 1'b0;
         flag_less     <= 1'b0;
         retired_count <= '0;
      end else begin
         if (accept) req_q <= {req_aluop, req_op1, req_op2, req_dest};
         if (state == EXEC) begin
            case (req_q.aluop)
               OP_SLT: begin
                  flag_less  <= alu_less;
                  flag_equal <= 1'b0;
               end
               OP_SLTE: begin
                  flag_less  <= alu_less;
                  flag_equal <= alu_equal;
               end
               OP_EQ: begin
                  flag_equal <= alu_equal;
                  flag_less  <= 1'b0;
               end
               default: begin
                  wb_data <= alu_result;
                  wb_dest <= req_q.dest;
               end
            endcase
         end
         if (retire) retired_count <= retired_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_alu_issue_unit.sv
// Bench for alu_issue_unit: behavioural ALU, vector table with writeback scoreboard,
// plus hand sequences for stall, reset-in-WB and counter wrap.
module tb_alu_issue_unit;

   logic       clk = 1'b0;
   logic       reset;
   logic       req_valid, req_ready;
   logic [2:0] req_aluop;
   logic [7:0] req_op1, req_op2;
   logic [2:0] req_dest;
   logic [7:0] alu_op1, alu_op2;
   logic [2:0] alu_aluop;
   logic [7:0] alu_result;
   logic       alu_equal, alu_less;
   logic       wb_valid, wb_ready;
   logic [2:0] wb_dest;
   logic [7:0] wb_data;
   logic       flag_equal, flag_less;
   logic [7:0] retired_count;

   always #5 clk = ~clk;

   alu_issue_unit #(.DATA_W(8), .DEST_W(3), .CNT_W(8)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_aluop(req_aluop),
      .req_op1(req_op1), .req_op2(req_op2), .req_dest(req_dest),
      .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_aluop(alu_aluop),
      .alu_result(alu_result), .alu_equal(alu_equal), .alu_less(alu_less),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_dest(wb_dest), .wb_data(wb_data),
      .flag_equal(flag_equal), .flag_less(flag_less), .retired_count(retired_count)
   );

   // ALU stand-in; its lessThan output means "<=" when the opcode is SLTE
   always_comb begin
      alu_result = 8'h00;
      alu_equal  = (alu_op1 == alu_op2);
      alu_less   = (alu_aluop == 3'b110) ? (alu_op1 <= alu_op2) : (alu_op1 < alu_op2);
      case (alu_aluop)
         3'b000:  alu_result = alu_op1 & alu_op2;
         3'b001:  alu_result = alu_op1 | alu_op2;
         3'b010:  alu_result = alu_op1 ^ alu_op2;
         3'b011:  alu_result = alu_op1 + alu_op2;
         3'b100:  alu_result = alu_op1 - alu_op2;
         default: alu_result = {7'b0, alu_less};
      endcase
   end

   typedef struct {
      logic [2:0] op;
      logic [7:0] a, b;
      logic [2:0] d;
      logic [7:0] exp;
      logic       eq, lt;
      int         stall;
   } vec_t;

   typedef struct {
      logic [2:0] dest;
      logic [7:0] data;
   } wb_t;

   vec_t       tbl[10];
   wb_t        sb[$];
   int         checks = 0;
   int         failures = 0;
   logic       exp_eq = 1'b0, exp_lt = 1'b0;
   logic [7:0] exp_ret = 8'h00;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("ready_wait", 32'(n < 20), 32'd1);
   endtask

   task automatic run_vec(input vec_t v);
      wb_t w;
      bit  cmp = (v.op >= 3'b101);
      wb_ready = (v.stall == 0);
      wait_ready();
      req_valid = 1'b1; req_aluop = v.op; req_op1 = v.a; req_op2 = v.b; req_dest = v.d;
      if (!cmp) sb.push_back('{dest: v.d, data: v.exp});
      @(negedge clk);
      req_valid = 1'b0;
      chk("exec_ready", 32'(req_ready), 32'd0);
      chk("alu_op1", 32'(alu_op1), 32'(v.a));
      chk("alu_op2", 32'(alu_op2), 32'(v.b));
      chk("alu_aluop", 32'(alu_aluop), 32'(v.op));
      @(negedge clk);
      if (cmp) begin
         exp_eq = v.eq; exp_lt = v.lt; exp_ret++;
         chk("cmp_no_wb", 32'(wb_valid), 32'd0);
         chk("cmp_idle", 32'(req_ready), 32'd1);
      end else begin
         chk("wb_latency", 32'(wb_valid), 32'd1);
         for (int s = 0; s < v.stall; s++) begin
            req_valid = 1'b1; req_aluop = 3'b011; req_op1 = 8'h33; req_op2 = 8'h44;
            #1;
            chk("stall_ready", 32'(req_ready), 32'd0);
            chk("stall_valid", 32'(wb_valid), 32'd1);
            chk("stall_data", 32'(wb_data), 32'(v.exp));
            chk("stall_dest", 32'(wb_dest), 32'(v.d));
            @(negedge clk);
         end
         req_valid = 1'b0;
         chk("no_spurious_accept", 32'(alu_op1), 32'(v.a));
         wb_ready = 1'b1;
         #1;
         chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
         if (sb.size() > 0) begin
            w = sb.pop_front();
            chk("wb_data", 32'(wb_data), 32'(w.data));
            chk("wb_dest", 32'(wb_dest), 32'(w.dest));
         end
         @(negedge clk);
         exp_ret++;
         chk("wb_drop", 32'(wb_valid), 32'd0);
      end
      chk("flag_equal", 32'(flag_equal), 32'(exp_eq));
      chk("flag_less", 32'(flag_less), 32'(exp_lt));
      chk("retired", 32'(retired_count), 32'(exp_ret));
   endtask

   initial begin
      int acc, last, cyc;
      tbl[0] = '{3'b011, 8'h7F, 8'h01, 3'd3, 8'h80, 1'b0, 1'b0, 0};  // ADD overflow into bit 7
      tbl[1] = '{3'b100, 8'h00, 8'h01, 3'd5, 8'hFF, 1'b0, 1'b0, 5};  // SUB wrap, stalled WB
      tbl[2] = '{3'b110, 8'h05, 8'h05, 3'd0, 8'h00, 1'b1, 1'b1, 0};  // SLTE equal
      tbl[3] = '{3'b010, 8'hAA, 8'h55, 3'd1, 8'hFF, 1'b0, 1'b0, 0};  // XOR, flags untouched
      tbl[4] = '{3'b111, 8'h10, 8'h20, 3'd0, 8'h00, 1'b0, 1'b0, 0};  // EQ false
      tbl[5] = '{3'b000, 8'hF0, 8'h3C, 3'd2, 8'h30, 1'b0, 1'b0, 0};  // AND
      tbl[6] = '{3'b001, 8'hF0, 8'h0F, 3'd7, 8'hFF, 1'b0, 1'b0, 1};  // OR, one stall cycle
      tbl[7] = '{3'b101, 8'h03, 8'h09, 3'd0, 8'h00, 1'b0, 1'b1, 0};  // SLT true
      tbl[8] = '{3'b011, 8'hFF, 8'h02, 3'd4, 8'h01, 1'b0, 1'b0, 0};  // ADD modulo
      tbl[9] = '{3'b111, 8'h42, 8'h42, 3'd0, 8'h00, 1'b1, 1'b0, 0};  // EQ true

      reset = 1'b1; req_valid = 1'b0; req_aluop = '0; req_op1 = '0; req_op2 = '0;
      req_dest = '0; wb_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_wb_valid", 32'(wb_valid), 32'd0);
      chk("rst_flags", 32'({flag_equal, flag_less}), 32'd0);
      chk("rst_retired", 32'(retired_count), 32'd0);
      chk("rst_alu_ops", 32'({alu_op1, alu_op2, alu_aluop}), 32'd0);
      chk("rst_ready", 32'(req_ready), 32'd1);
      chk("rst_wb_regs", 32'({wb_dest, wb_data}), 32'd0);
      reset = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 10; i++) run_vec(tbl[i]);

      // reset while a writeback is stalled: op dropped, everything cleared
      wb_ready = 1'b0;
      wait_ready();
      req_valid = 1'b1; req_aluop = 3'b011; req_op1 = 8'h01; req_op2 = 8'h01; req_dest = 3'd6;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      chk("pre_rst_wb", 32'(wb_valid), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("wbrst_valid", 32'(wb_valid), 32'd0);
      chk("wbrst_ready", 32'(req_ready), 32'd1);
      chk("wbrst_retired", 32'(retired_count), 32'd0);
      chk("wbrst_flags", 32'({flag_equal, flag_less}), 32'd0);
      exp_ret = 8'h00; exp_eq = 1'b0; exp_lt = 1'b0;

      // 256 back-to-back EQ ops: accepts exactly 2 cycles apart, counter wraps to 0
      wb_ready = 1'b1;
      req_valid = 1'b1; req_aluop = 3'b111; req_op1 = 8'h5A; req_op2 = 8'h5A;
      acc = 0; last = -2; cyc = 0;
      while (acc < 256 && cyc < 600) begin
         if (req_ready) begin
            if (acc > 0) chk("b2b_spacing", 32'(cyc - last), 32'd2);
            last = cyc;
            acc++;
         end
         @(negedge clk);
         cyc++;
      end
      chk("b2b_accepts", 32'(acc), 32'd256);
      req_valid = 1'b0;
      @(negedge clk);
      chk("wrap_retired", 32'(retired_count), 32'd0);
      chk("wrap_flag_eq", 32'(flag_equal), 32'd1);
      chk("sb_drained", 32'(sb.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
